// File: rtl/xcvr646_seq.sv
// Sequencer/arbiter for a shared 74646 registered bus transceiver.
// Optional transfer counters: define XCVR646_SEQ_STATS_EN.
module xcvr646_seq #(
   parameter int SETUP_CYC = 1,
   parameter int DRIVE_CYC = 2
) (
   input  logic sysclk,
   input  logic sys_rst,
   input  logic a_req,
   input  logic a_store,
   output logic a_ack,
   input  logic b_req,
   input  logic b_store,
   output logic b_ack,
   output logic busy,
   output logic last_grant,
   output logic DIR,
   output logic OE_n,
   output logic CLKAB,
   output logic CLKBA,
   output logic SAB,
   output logic SBA
`ifdef XCVR646_SEQ_STATS_EN
   ,
   output logic [15:0] xfer_cnt_a,
   output logic [15:0] xfer_cnt_b
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      CAPTURE,
      HOLD,
      DRIVE,
      RELEASE
   } state_t;

   state_t     state;
   logic [3:0] cnt;
   logic       grantB;
   logic       storeSel;
   logic       pickB;
   logic       anyReq;

   // Round-robin: on a tie the side not granted last time wins.
   always_comb begin
      anyReq = a_req | b_req;
      pickB  = b_req & (~a_req | ~last_grant);
   end

   always_ff @(posedge sysclk) begin
      if (sys_rst) begin
         state      <= IDLE;
         cnt        <= '0;
         grantB     <= 1'b0;
         storeSel   <= 1'b0;
         last_grant <= 1'b1;
         busy       <= 1'b0;
         DIR        <= 1'b0;
         OE_n       <= 1'b1;
         CLKAB      <= 1'b0;
         CLKBA      <= 1'b0;
         SAB        <= 1'b0;
         SBA        <= 1'b0;
         a_ack      <= 1'b0;
         b_ack      <= 1'b0;
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (anyReq) begin
                  grantB     <= pickB;
                  storeSel   <= pickB ? b_store : a_store;
                  last_grant <= pickB;
                  DIR        <= ~pickB;
                  busy       <= 1'b1;
                  cnt        <= 4'(SETUP_CYC);
                  state      <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == 4'd1) begin
                  if (storeSel) begin
                     CLKAB <= ~grantB;
                     CLKBA <= grantB;
                     state <= CAPTURE;
                  end else begin
                     OE_n  <= 1'b0;
                     SAB   <= 1'b0;
                     SBA   <= 1'b0;
                     cnt   <= 4'(DRIVE_CYC);
                     state <= DRIVE;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            CAPTURE: begin
               CLKAB <= 1'b0;
               CLKBA <= 1'b0;
               state <= HOLD;
            end
            HOLD: begin
               OE_n  <= 1'b0;
               SAB   <= ~grantB & storeSel;
               SBA   <= grantB & storeSel;
               cnt   <= 4'(DRIVE_CYC);
               state <= DRIVE;
            end
            DRIVE: begin
               if (cnt == 4'd1) begin
                  OE_n  <= 1'b1;
                  SAB   <= 1'b0;
                  SBA   <= 1'b0;
                  a_ack <= ~grantB;
                  b_ack <= grantB;
                  state <= RELEASE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RELEASE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef XCVR646_SEQ_STATS_EN
   always_ff @(posedge sysclk) begin
      if (sys_rst) begin
         xfer_cnt_a <= '0;
         xfer_cnt_b <= '0;
      end else begin
         if (a_ack) xfer_cnt_a <= xfer_cnt_a + 16'd1;
         if (b_ack) xfer_cnt_b <= xfer_cnt_b + 16'd1;
      end
   end
`endif

endmodule
